mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported, synchronous-read data memory between two requesters.
  - Requester 0: load/store path.
  - Requester 1: debug/program loader.
- Round-robin arbitration; one transaction outstanding at a time.
- Request and response channels use valid/ready handshakes.
- Sequences the memory enable, write enable and read capture, and checks address alignment and range before touching memory.

Parameters:
- SIZE, 128, memory depth in 32-bit words; must be a power of two.
- ADDR_W, 7, word-index width, equal to log2(SIZE).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  per-requester request accepted
- req_addr0, req_addr1  in  32 each  byte address
- req_wdata0, req_wdata1  in  32 each  write data
- req_we  in  2  1 = store, 0 = load
- resp_valid  out  2  per-requester response valid
- resp_ready  in  2  per-requester response accepted
- resp_rdata  out  32  read data; 0 for stores and errors
- resp_err  out  1  misaligned or out-of-range access
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  word index
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data; valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset (asynchronous, rst=0) applies immediately, mid-transaction included:
  - state=IDLE; all outputs 0; last_grant=1; captured registers 0.
  - Any in-flight transaction is dropped; no response is issued for it.
- FSM states: IDLE, MEM, WAIT, RESP.
- IDLE:
  - grant = the only valid requester. If both are valid, grant = ~last_grant.
  - req_ready[grant]=1 combinationally, only in IDLE.
  - On handshake: capture owner, addr, wdata, we; set last_grant=grant.
  - Legality: addr[1:0]==0 and addr[31:2] < SIZE.
  - Legal access: go to MEM. Illegal access: set err=1, rdata=0, go to RESP with no memory access.
- MEM (one cycle):
  - mem_en=1, mem_we=we, mem_addr=addr[ADDR_W+1:2], mem_wdata=wdata.
  - Store: go to RESP with rdata=0.
  - Load: go to WAIT.
- WAIT (one cycle): capture mem_rdata into the response register; go to RESP.
- RESP:
  - resp_valid[owner]=1, other bit 0; resp_rdata and resp_err held stable.
  - On resp_ready[owner]: go to IDLE.
  - resp_ready on the non-owner bit is ignored.
- Latency from the request handshake edge to resp_valid:
  - load: 3 cycles
  - store: 2 cycles
  - error: 1 cycle
- Throughput: the next request is accepted in the cycle after the response handshake, never in the same cycle.
- mem_en and mem_we are 0 in every state except MEM; mem_addr and mem_wdata are don't-care outside MEM.
- A request that is not granted must remain asserted by its requester; the arbiter holds no request state for it.
- Simultaneous requests alternate strictly, so neither requester can be starved.

Decomposition:
- Shared package:
  - state encoding localparams: IDLE=0, MEM=1, WAIT=2, RESP=3
  - RV opcode constants LOAD=7'b0000011 and STORE=7'b0100011, shared with the memory-access stage.
- One sub-module: rr_arb2.
  - Purely combinational grant from req_valid and last_grant.
  - Reusable by the future instruction/data bus mux.
- The FSM, address check and response registers stay in mem_arbiter.

Test Plan:
- Reset check: rst low mid-sequence -> all outputs 0 immediately, with no clock edge needed.
- Single load: requester 0 loads addr 0x10 while mem_rdata=0xDEADBEEF in WAIT.
  - mem_en=1 and mem_addr=4 exactly one cycle after the handshake.
  - resp_valid=2'b01 and resp_rdata=0xDEADBEEF 3 cycles after the handshake.
- Store then load: requester 1 stores 0xCAFEF00D to 0x1FC (index 127), then loads it back.
  - mem_we=1 in the MEM cycle; store response has rdata=0.
  - Load returns 0xCAFEF00D when a bench memory model is attached.
- Contention: both requesters hold valid for 4 transactions.
  - Grants go 0,1,0,1.
  - req_ready is never high for both requesters, and never high outside IDLE.
- Errors: load from addr 0x2 and store to 0x200 with SIZE=128.
  - resp_err=1 and rdata=0 one cycle after the handshake.
  - mem_en stays 0 throughout.
- Backpressure: hold resp_ready=0 for 5 cycles.
  - resp_valid, resp_rdata and resp_err stay stable.
  - No new req_ready; IDLE is re-entered after resp_ready=1.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter and the memory-access stage.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  // Word-aligned and inside a memory of `size` 32-bit words.
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned size);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < size);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not served last.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       any
);

  always_comb begin
    any = |req_valid;
    case (req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-ported synchronous-read data memory between the load/store path (0)
// and the debug/program loader (1), one transaction at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int SIZE   = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [31:0]       req_addr0,
  input  logic [31:0]       req_addr1,
  input  logic [31:0]       req_wdata0,
  input  logic [31:0]       req_wdata1,
  input  logic [1:0]        req_we,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e              state, state_nx;
  logic                owner, last_grant;
  logic [6:0]          op;
  logic [ADDR_W-1:0]   idx;
  logic [31:0]         wdata, rdata;
  logic                err;

  logic                grant, any, handshake, legal, sel_we;
  logic [31:0]         sel_addr, sel_wdata;

  rr_arb2 u_arb (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .any        (any)
  );

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    sel_addr  = grant ? req_addr1  : req_addr0;
    sel_wdata = grant ? req_wdata1 : req_wdata0;
    sel_we    = req_we[grant];
    legal     = addr_legal(sel_addr, SIZE);
    handshake = (state == IDLE) && any;

    state_nx = state;
    case (state)
      IDLE:    if (handshake) state_nx = legal ? MEM : RESP;
      MEM:     state_nx = (op == STORE) ? RESP : WAIT;
      WAIT:    state_nx = RESP;
      RESP:    if (resp_ready[owner]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // req_ready is combinational, so it is gated by rst to read 0 while reset is held.
  always_comb begin
    req_ready = 2'b00;
    if (handshake && rst) req_ready[grant] = 1'b1;

    mem_en    = (state == MEM);
    mem_we    = mem_en && (op == STORE);
    mem_addr  = idx;
    mem_wdata = wdata;

    resp_valid = 2'b00;
    if (state == RESP) resp_valid[owner] = 1'b1;
    resp_rdata = (state == RESP) ? rdata : '0;
    resp_err   = (state == RESP) && err;
  end

  // NOTE: state and captured registers update with non-blocking assignments so every
  // flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      op         <= '0;
      idx        <= '0;
      wdata      <= '0;
      rdata      <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (handshake) begin
          owner      <= grant;
          last_grant <= grant;
          op         <= sel_we ? STORE : LOAD;
          idx        <= sel_addr[ADDR_W+1:2];
          wdata      <= sel_wdata;
          err        <= ~legal;
          rdata      <= '0;
        end
        WAIT:    rdata <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level latency model checks every cycle,
// and literal expectations pin the key scenarios.
module tb_mem_arbiter;

  localparam int SIZE = 128;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid, req_ready, req_we, resp_valid, resp_ready;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [31:0] resp_rdata, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        resp_err, mem_en, mem_we;
  logic [6:0]  mem_addr;

  logic [1:0]  v_r = 2'b00;
  logic [1:0]  w_r = 2'b00;
  logic [31:0] a_r [2] = '{32'h0, 32'h0};
  logic [31:0] d_r [2] = '{32'h0, 32'h0};

  assign req_valid  = v_r;
  assign req_we     = w_r;
  assign req_addr0  = a_r[0];
  assign req_addr1  = a_r[1];
  assign req_wdata0 = d_r[0];
  assign req_wdata1 = d_r[1];

  req_t        q0[$], q1[$];
  int          hs_cnt [2] = '{0, 0};
  int          grant_log[$];
  logic [31:0] resp_log[$];
  logic [31:0] dmem    [SIZE];
  logic [31:0] ref_mem [SIZE];

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.SIZE(SIZE), .ADDR_W(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .req_we     (req_we),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous-read memory attached to the arbiter.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) dmem[mem_addr] <= mem_wdata;
      else        mem_rdata      <= dmem[mem_addr];
    end
  end

  // Requesters: hold valid until accepted, then present the next queued request.
  initial begin : driver
    logic [1:0] took;
    req_t       r;
    forever begin
      @(negedge clk);
      took = req_valid & req_ready & {2{rst}};
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (took[i]) begin
          v_r[i] = 1'b0;
          hs_cnt[i]++;
          grant_log.push_back(i);
        end
      end
      if (!rst) v_r = 2'b00;
      if (rst && !v_r[0] && q0.size() > 0) begin
        r = q0.pop_front();
        a_r[0] = r.addr; d_r[0] = r.wdata; w_r[0] = r.we; v_r[0] = 1'b1;
      end
      if (rst && !v_r[1] && q1.size() > 0) begin
        r = q1.pop_front();
        a_r[1] = r.addr; d_r[1] = r.wdata; w_r[1] = r.we; v_r[1] = 1'b1;
      end
    end
  end

  // Transaction model: one access at a time, response N cycles after acceptance
  // (load 3, store 2, error 1), held until the owner takes it.
  bit          m_busy  = 1'b0;
  bit          m_last  = 1'b1;
  int          m_k, m_lat, m_owner, m_idx;
  bit          m_err, m_store, m_legal;
  logic [31:0] m_rdata, m_wdata;

  always @(negedge clk) begin : model
    int          g;
    logic [31:0] a;
    if (!rst) begin
      check("rst_req_ready",  32'(req_ready),  32'h0);
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_mem_en",     32'(mem_en),     32'h0);
      check("rst_resp_rdata", resp_rdata,      32'h0);
      m_busy = 1'b0;
      m_last = 1'b1;
    end else if (!m_busy) begin
      g = (req_valid == 2'b10) ? 1 : (req_valid == 2'b11) ? int'(!m_last) : 0;
      check("idle_req_ready",  32'(req_ready),  (req_valid == 2'b00) ? 32'h0 : 32'(1 << g));
      check("idle_mem_en",     32'(mem_en),     32'h0);
      check("idle_resp_valid", 32'(resp_valid), 32'h0);
      if (req_valid != 2'b00) begin
        a        = (g == 1) ? req_addr1 : req_addr0;
        m_owner  = g;
        m_last   = (g == 1);
        m_store  = req_we[g];
        m_wdata  = (g == 1) ? req_wdata1 : req_wdata0;
        m_legal  = (a % 4 == 0) && ((a >> 2) < 32'(SIZE));
        m_idx    = int'(a[8:2]);
        m_err    = !m_legal;
        m_lat    = !m_legal ? 1 : (m_store ? 2 : 3);
        m_rdata  = (m_legal && !m_store) ? ref_mem[m_idx] : 32'h0;
        if (m_legal && m_store) ref_mem[m_idx] = m_wdata;
        m_busy   = 1'b1;
        m_k      = 0;
      end
    end else begin
      m_k++;
      check("busy_req_ready", 32'(req_ready), 32'h0);
      check("busy_mem_en", 32'(mem_en), 32'(m_legal && m_k == 1));
      check("busy_mem_we", 32'(mem_we), 32'(m_legal && m_k == 1 && m_store));
      if (m_legal && m_k == 1) begin
        check("mem_addr", 32'(mem_addr), 32'(m_idx));
        if (m_store) check("mem_wdata", mem_wdata, m_wdata);
      end
      if (m_k >= m_lat) begin
        check("resp_valid", 32'(resp_valid), 32'(1 << m_owner));
        check("resp_rdata", resp_rdata, m_rdata);
        check("resp_err",   32'(resp_err), 32'(m_err));
        if (resp_ready[m_owner]) begin
          resp_log.push_back(resp_rdata);
          m_busy = 1'b0;
        end
      end else begin
        check("early_resp_valid", 32'(resp_valid), 32'h0);
      end
    end
  end

  task automatic push(input int i, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic we);
    req_t r;
    r.addr = addr; r.wdata = wdata; r.we = we;
    if (i == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  // Returns on the first negedge after requester i's next acceptance (the cycle after handshake).
  task automatic wait_hs(input int i);
    int start;
    start = hs_cnt[i];
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (hs_cnt[i] > start) return;
    end
    check("hs_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && req_valid == 2'b00 && !m_busy) return;
    end
    check("idle_timeout", 32'h0, 32'h1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int gl;
    resp_ready = 2'b11;
    for (int i = 0; i < SIZE; i++) begin
      dmem[i]    = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    dmem[4]    = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    // Single load from requester 0.
    push(0, 32'h10, 32'h0, 1'b0);
    wait_hs(0);
    check("ld_mem_en",   32'(mem_en),   32'h1);
    check("ld_mem_addr", 32'(mem_addr), 32'h4);
    @(negedge clk);
    check("ld_wait_no_resp", 32'(resp_valid), 32'h0);
    @(negedge clk);
    check("ld_resp_valid", 32'(resp_valid), 32'h1);
    check("ld_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
    wait_idle(20);

    // Store then load back at the last word.
    push(1, 32'h1FC, 32'hCAFE_F00D, 1'b1);
    wait_hs(1);
    check("st_mem_we",    32'(mem_we),    32'h1);
    check("st_mem_addr",  32'(mem_addr),  32'd127);
    check("st_mem_wdata", mem_wdata,      32'hCAFE_F00D);
    @(negedge clk);
    check("st_resp_valid", 32'(resp_valid), 32'h2);
    check("st_resp_rdata", resp_rdata,      32'h0);
    wait_idle(20);
    push(1, 32'h1FC, 32'h0, 1'b0);
    wait_hs(1);
    repeat (2) @(negedge clk);
    check("ldback_rdata", resp_rdata, 32'hCAFE_F00D);
    wait_idle(20);

    // Contention: both requesters hold valid across four transactions.
    gl = grant_log.size();
    push(0, 32'h0, 32'h0, 1'b0);
    push(0, 32'h8, 32'h1234_5678, 1'b1);
    push(1, 32'h1FC, 32'h0, 1'b0);
    push(1, 32'h8, 32'h0, 1'b0);
    wait_idle(100);
    check("cont_count", 32'(grant_log.size() - gl), 32'd4);
    if (grant_log.size() >= gl + 4)
      for (int k = 0; k < 4; k++) check("cont_grant", 32'(grant_log[gl+k]), 32'(k % 2));
    if (resp_log.size() > 0)
      check("cont_last_rdata", resp_log[resp_log.size()-1], 32'h1234_5678);

    // Misaligned load and out-of-range store.
    push(0, 32'h2, 32'h0, 1'b0);
    wait_hs(0);
    check("err_ld_valid", 32'(resp_valid), 32'h1);
    check("err_ld_err",   32'(resp_err),   32'h1);
    check("err_ld_rdata", resp_rdata,      32'h0);
    wait_idle(20);
    push(1, 32'h200, 32'h55, 1'b1);
    wait_hs(1);
    check("err_st_valid", 32'(resp_valid), 32'h2);
    check("err_st_err",   32'(resp_err),   32'h1);
    check("err_st_mem_en", 32'(mem_en),    32'h0);
    wait_idle(20);

    // Backpressure: owner holds resp_ready low, non-owner's resp_ready is ignored.
    resp_ready = 2'b10;
    push(0, 32'h10, 32'h0, 1'b0);
    wait_hs(0);
    push(1, 32'h8, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid",     32'(resp_valid), 32'h1);
      check("bp_rdata",     resp_rdata,      32'hDEAD_BEEF);
      check("bp_req_ready", 32'(req_ready),  32'h0);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk);
    #1 resp_ready = 2'b11;
    @(negedge clk);
    check("bp_release_no_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    check("bp_idle_ready", 32'(req_ready), 32'h2);
    wait_idle(30);

    // Asynchronous reset in the middle of a load.
    push(0, 32'h10, 32'h0, 1'b0);
    wait_hs(0);
    #2 rst = 1'b0;
    #1;
    check("arst_req_ready",  32'(req_ready),  32'h0);
    check("arst_resp_valid", 32'(resp_valid), 32'h0);
    check("arst_mem_en",     32'(mem_en),     32'h0);
    check("arst_mem_we",     32'(mem_we),     32'h0);
    check("arst_mem_addr",   32'(mem_addr),   32'h0);
    check("arst_mem_wdata",  mem_wdata,       32'h0);
    check("arst_resp_err",   32'(resp_err),   32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (3) @(negedge clk);
    gl = grant_log.size();
    push(0, 32'h0, 32'h0, 1'b0);
    push(1, 32'h4, 32'h0, 1'b0);
    wait_idle(50);
    check("post_rst_count", 32'(grant_log.size() - gl), 32'd2);
    if (grant_log.size() >= gl + 2) begin
      check("post_rst_first",  32'(grant_log[gl]),   32'h0);
      check("post_rst_second", 32'(grant_log[gl+1]), 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
